hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RV32 core. It drives the EX-stage forwarding selects (`Asel_haz`, `Bsel_haz`), the per-stage pipeline-register enables and the flush (`reset`) controls. It sequences load-use bubbles, branch flushes and whole-pipe freezes while a cache or AES access in MEM is outstanding. A watchdog detects hung memory accesses.

---
 rtl/cpu_pkg.sv | 6 +
 rtl/fwd_unit.sv | 15 +
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline-control types for the five-stage RV32 core.
package cpu_pkg;
   typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2} fwd_sel_e;
   typedef enum logic [1:0] {RUN, WAIT, TRAP} haz_state_e;
   localparam logic [1:0] WB_SEL_MEM = 2'b00;
endpackage

// File: rtl/fwd_unit.sv
// fwd_unit: per-operand EX forwarding select; MEM beats WB, x0 never forwarded.
module fwd_unit
   import cpu_pkg::*;
(
   input  logic [4:0] rs_i,
   input  logic [4:0] rsW_mem_i,
   input  logic [4:0] rsW_wb_i,
   input  logic       RegWEn_mem_i,
   input  logic       RegWEn_wb_i,
   output logic [1:0] sel_o
);
   always_comb
      sel_o = (RegWEn_mem_i && rsW_mem_i != 5'd0 && rsW_mem_i == rs_i) ? FWD_MEM :
              (RegWEn_wb_i && rsW_wb_i != 5'd0 && rsW_wb_i == rs_i)    ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use bubbles, branch flushes, memory freeze and watchdog.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 256
`ifdef HAZ_PERF_CNT_EN
   ,
   parameter int CNT_W = 32
`endif
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [4:0] rs1_id_i,
   input  logic [4:0] rs2_id_i,
   input  logic [4:0] rs1_ex_i,
   input  logic [4:0] rs2_ex_i,
   input  logic [4:0] rsW_ex_i,
   input  logic [4:0] rsW_mem_i,
   input  logic [4:0] rsW_wb_i,
   input  logic       RegWEn_ex_i,
   input  logic       RegWEn_mem_i,
   input  logic       RegWEn_wb_i,
   input  logic [1:0] WBSel_ex_i,
   input  logic       br_taken_i,
   input  logic       Valid_cpu2cache_mem_i,
   input  logic       Valid_cpu2aes_mem_i,
   input  logic       cache_ready_i,
   input  logic       aes_ready_i,
   output logic [1:0] Asel_haz_o,
   output logic [1:0] Bsel_haz_o,
   output logic       en_if_o,
   output logic       en_id_o,
   output logic       en_ex_o,
   output logic       en_mem_o,
   output logic       en_wb_o,
   output logic       flush_id_o,
   output logic       flush_ex_o,
`ifdef HAZ_PERF_CNT_EN
   output logic             timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
`else
   output logic             timeout_o
`endif
);
   localparam int WC_W = $clog2(MEM_TIMEOUT);

   haz_state_e      state_q, state_d;
   logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
   logic            timeout_q, timeout_d;
   logic            mem_busy, load_use, freeze, stall;

   fwd_unit u_fwd_a (
      .rs_i(rs1_ex_i), .rsW_mem_i(rsW_mem_i), .rsW_wb_i(rsW_wb_i),
      .RegWEn_mem_i(RegWEn_mem_i), .RegWEn_wb_i(RegWEn_wb_i), .sel_o(Asel_haz_o)
   );
   fwd_unit u_fwd_b (
      .rs_i(rs2_ex_i), .rsW_mem_i(rsW_mem_i), .rsW_wb_i(rsW_wb_i),
      .RegWEn_mem_i(RegWEn_mem_i), .RegWEn_wb_i(RegWEn_wb_i), .sel_o(Bsel_haz_o)
   );

   always_comb begin
      mem_busy = (Valid_cpu2cache_mem_i & ~cache_ready_i) | (Valid_cpu2aes_mem_i & ~aes_ready_i);
      load_use = RegWEn_ex_i && WBSel_ex_i == WB_SEL_MEM && rsW_ex_i != 5'd0 &&
                 (rsW_ex_i == rs1_id_i || rsW_ex_i == rs2_id_i);
      // freeze acts the same cycle busy appears, not one cycle later via the FSM
      freeze   = mem_busy || state_q == TRAP;
      stall    = load_use && !br_taken_i;
      en_if_o    = !freeze && !stall;
      en_id_o    = !freeze && !stall;
      en_ex_o    = !freeze;
      en_mem_o   = !freeze;
      en_wb_o    = !freeze;
      flush_id_o = !freeze && br_taken_i;
      flush_ex_o = !freeze && (br_taken_i || load_use);
      state_d    = state_q;
      timeout_d  = timeout_q;
      wait_cnt_d = (state_q == WAIT && mem_busy) ? wait_cnt_q + 1'b1 : '0;
      if (state_q == RUN && mem_busy)
         state_d = WAIT;
      else if (state_q == WAIT && !mem_busy)
         state_d = RUN;
      else if (state_q == WAIT && wait_cnt_q == WC_W'(MEM_TIMEOUT - 1)) begin
         state_d   = TRAP;
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i)
      if (rst_i) begin
         state_q    <= RUN;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end

   assign timeout_o = timeout_q;

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   assign stall_cnt_d = stall_cnt_q + CNT_W'(!en_if_o);
   assign flush_cnt_d = flush_cnt_q + CNT_W'(flush_id_o);
   always_ff @(posedge clk_i)
      if (rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus multi-cycle stall, watchdog and reset sequences.
module tb_hazard_ctrl;
   logic       clk = 1'b0, rst = 1'b0;
   logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rsW_ex, rsW_mem, rsW_wb;
   logic       we_ex, we_mem, we_wb, br, vc, va, cr, ar;
   logic [1:0] wbsel;
   logic [1:0] asel, bsel, asel4, bsel4;
   logic       en_if, en_id, en_ex, en_mem, en_wb, fl_id, fl_ex, tmo;
   logic       en_if4, en_id4, en_ex4, en_mem4, en_wb4, fl_id4, fl_ex4, tmo4;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt, stall_cnt4, flush_cnt4;
`endif
   int nvec = 0, nerr = 0;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk_i(clk), .rst_i(rst), .rs1_id_i(rs1_id), .rs2_id_i(rs2_id),
      .rs1_ex_i(rs1_ex), .rs2_ex_i(rs2_ex), .rsW_ex_i(rsW_ex), .rsW_mem_i(rsW_mem),
      .rsW_wb_i(rsW_wb), .RegWEn_ex_i(we_ex), .RegWEn_mem_i(we_mem), .RegWEn_wb_i(we_wb),
      .WBSel_ex_i(wbsel), .br_taken_i(br), .Valid_cpu2cache_mem_i(vc),
      .Valid_cpu2aes_mem_i(va), .cache_ready_i(cr), .aes_ready_i(ar),
      .Asel_haz_o(asel), .Bsel_haz_o(bsel), .en_if_o(en_if), .en_id_o(en_id),
      .en_ex_o(en_ex), .en_mem_o(en_mem), .en_wb_o(en_wb), .flush_id_o(fl_id),
      .flush_ex_o(fl_ex),
`ifdef HAZ_PERF_CNT_EN
      .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
`endif
      .timeout_o(tmo)
   );

   hazard_ctrl #(.MEM_TIMEOUT(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .rs1_id_i(rs1_id), .rs2_id_i(rs2_id),
      .rs1_ex_i(rs1_ex), .rs2_ex_i(rs2_ex), .rsW_ex_i(rsW_ex), .rsW_mem_i(rsW_mem),
      .rsW_wb_i(rsW_wb), .RegWEn_ex_i(we_ex), .RegWEn_mem_i(we_mem), .RegWEn_wb_i(we_wb),
      .WBSel_ex_i(wbsel), .br_taken_i(br), .Valid_cpu2cache_mem_i(vc),
      .Valid_cpu2aes_mem_i(va), .cache_ready_i(cr), .aes_ready_i(ar),
      .Asel_haz_o(asel4), .Bsel_haz_o(bsel4), .en_if_o(en_if4), .en_id_o(en_id4),
      .en_ex_o(en_ex4), .en_mem_o(en_mem4), .en_wb_o(en_wb4), .flush_id_o(fl_id4),
      .flush_ex_o(fl_ex4),
`ifdef HAZ_PERF_CNT_EN
      .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4),
`endif
      .timeout_o(tmo4)
   );

   typedef struct {
      logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rsW_ex, rsW_mem, rsW_wb;
      logic       we_ex, we_mem, we_wb;
      logic [1:0] wbsel;
      logic       br, vc, cr, va, ar;
      logic [1:0] asel, bsel;
      logic       en_if, en_ex, fl_id, fl_ex;
   } vec_t;

   vec_t vt[12];

   function automatic vec_t mk(input int a, b, c, d, e, f, g, h, i, j, k, l, m, n, o, p,
                               input int q, r, s, t, u, w);
      vec_t v;
      v.rs1_id = 5'(a); v.rs2_id = 5'(b); v.rs1_ex = 5'(c); v.rs2_ex = 5'(d);
      v.rsW_ex = 5'(e); v.rsW_mem = 5'(f); v.rsW_wb = 5'(g);
      v.we_ex = 1'(h); v.we_mem = 1'(i); v.we_wb = 1'(j); v.wbsel = 2'(k);
      v.br = 1'(l); v.vc = 1'(m); v.cr = 1'(n); v.va = 1'(o); v.ar = 1'(p);
      v.asel = 2'(q); v.bsel = 2'(r); v.en_if = 1'(s); v.en_ex = 1'(t);
      v.fl_id = 1'(u); v.fl_ex = 1'(w);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      {rs1_id, rs2_id, rs1_ex, rs2_ex, rsW_ex, rsW_mem, rsW_wb} = '0;
      {we_ex, we_mem, we_wb, br, vc, va} = '0;
      wbsel = 2'b01;
      cr = 1'b1;
      ar = 1'b1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      //         rs1i rs2i rs1e rs2e rWe rWm rWw weE weM weW wbs br vc cr va ar  A  B eIF eEX fID fEX
      vt[0]  = mk(0, 0, 5, 0, 5, 5, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 1, 1, 0, 0);
      vt[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0);
      vt[2]  = mk(0, 0, 0, 7, 0, 0, 7, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 2, 1, 1, 0, 0);
      vt[3]  = mk(0, 0, 3, 3, 0, 3, 3, 0, 1, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 0, 0);
      vt[4]  = mk(0, 0, 3, 0, 0, 3, 3, 0, 0, 1, 1, 0, 0, 1, 0, 1, 2, 0, 1, 1, 0, 0);
      vt[5]  = mk(0, 6, 0, 0, 6, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1);
      vt[6]  = mk(6, 0, 0, 0, 6, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0);
      vt[7]  = mk(6, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1, 0, 0);
      vt[8]  = mk(0, 6, 0, 0, 6, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1, 1, 1);
      vt[9]  = mk(0, 6, 5, 0, 6, 5, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      vt[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      vt[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0);

      do_reset();
      #1;
      chk("reset_timeout", 32'(tmo), 0);
      chk("reset_timeout4", 32'(tmo4), 0);
      chk("reset_en_if", 32'(en_if), 1);
`ifdef HAZ_PERF_CNT_EN
      chk("reset_stall_cnt", stall_cnt, 0);
      chk("reset_flush_cnt", flush_cnt, 0);
`endif

      for (int i = 0; i < 12; i++) begin
         rs1_id = vt[i].rs1_id; rs2_id = vt[i].rs2_id; rs1_ex = vt[i].rs1_ex;
         rs2_ex = vt[i].rs2_ex; rsW_ex = vt[i].rsW_ex; rsW_mem = vt[i].rsW_mem;
         rsW_wb = vt[i].rsW_wb; we_ex = vt[i].we_ex; we_mem = vt[i].we_mem;
         we_wb = vt[i].we_wb; wbsel = vt[i].wbsel; br = vt[i].br;
         vc = vt[i].vc; cr = vt[i].cr; va = vt[i].va; ar = vt[i].ar;
         #1;
         chk($sformatf("v%0d_asel", i), 32'(asel), 32'(vt[i].asel));
         chk($sformatf("v%0d_bsel", i), 32'(bsel), 32'(vt[i].bsel));
         chk($sformatf("v%0d_en_if", i), 32'(en_if), 32'(vt[i].en_if));
         chk($sformatf("v%0d_en_id", i), 32'(en_id), 32'(vt[i].en_if));
         chk($sformatf("v%0d_en_ex", i), 32'(en_ex), 32'(vt[i].en_ex));
         chk($sformatf("v%0d_en_mem", i), 32'(en_mem), 32'(vt[i].en_ex));
         chk($sformatf("v%0d_en_wb", i), 32'(en_wb), 32'(vt[i].en_ex));
         chk($sformatf("v%0d_flush_id", i), 32'(fl_id), 32'(vt[i].fl_id));
         chk($sformatf("v%0d_flush_ex", i), 32'(fl_ex), 32'(vt[i].fl_ex));
         tick();
      end

      // load-use bubble, then the consumer takes lw data from WB
      do_reset();
      rs2_id = 5'd6; rsW_ex = 5'd6; we_ex = 1'b1; wbsel = 2'b00;
      #1;
      chk("lu_en_if", 32'(en_if), 0);
      chk("lu_flush_ex", 32'(fl_ex), 1);
      tick();
      idle();
      rs2_ex = 5'd6; rsW_wb = 5'd6; we_wb = 1'b1;
      #1;
      chk("lu_next_bsel", 32'(bsel), 2);
      chk("lu_next_en_if", 32'(en_if), 1);
`ifdef HAZ_PERF_CNT_EN
      chk("lu_stall_cnt", stall_cnt, 1);
`endif

      // branch with load-use: flush counted, no stall
      do_reset();
      rs2_id = 5'd6; rsW_ex = 5'd6; we_ex = 1'b1; wbsel = 2'b00; br = 1'b1;
      #1;
      chk("br_en_if", 32'(en_if), 1);
      chk("br_flush_id", 32'(fl_id), 1);
      tick();
      idle();
      #1;
`ifdef HAZ_PERF_CNT_EN
      chk("br_flush_cnt", flush_cnt, 1);
      chk("br_stall_cnt", stall_cnt, 0);
`endif

      // 5-cycle cache stall: default watchdog survives, MEM_TIMEOUT=4 traps
      do_reset();
      vc = 1'b1; cr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("cs%0d_en_if", i), 32'(en_if), 0);
         chk($sformatf("cs%0d_en_wb", i), 32'(en_wb), 0);
         tick();
      end
      cr = 1'b1;
      #1;
      chk("cs_done_en_if", 32'(en_if), 1);
      chk("cs_done_timeout", 32'(tmo), 0);
      chk("cs_timeout4", 32'(tmo4), 1);
`ifdef HAZ_PERF_CNT_EN
      chk("cs_stall_cnt", stall_cnt, 5);
`endif
      tick();
      vc = 1'b0;
      #1;
      chk("cs_run_en_ex", 32'(en_ex), 1);

      // exactly MEM_TIMEOUT busy cycles completes without trapping
      do_reset();
      va = 1'b1; ar = 1'b0;
      repeat (4) tick();
      ar = 1'b1;
      tick();
      va = 1'b0;
      #1;
      chk("wd4_no_trap", 32'(tmo4), 0);
      chk("wd4_en_if", 32'(en_if4), 1);

      // AES never ready: trap on the fifth busy edge, sticky until reset
      do_reset();
      va = 1'b1; ar = 1'b0;
      repeat (4) tick();
      #1;
      chk("wd4_before_trap", 32'(tmo4), 0);
      tick();
      #1;
      chk("wd4_trap", 32'(tmo4), 1);
      ar = 1'b1;
      tick();
      #1;
      chk("wd4_trap_held", 32'(tmo4), 1);
      chk("wd4_trap_en_if", 32'(en_if4), 0);
      chk("wd4_trap_en_wb", 32'(en_wb4), 0);
      do_reset();
      #1;
      chk("wd4_reset_timeout", 32'(tmo4), 0);
      chk("wd4_reset_en_if", 32'(en_if4), 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
